// File: rtl/arbitro_fifos_if.sv
// Datapath bundle between arbitro_fifos and the eight switch FIFOs
// (four entry FIFOs FIFOE_0..3, four exit FIFOs FIFOS_0..3).
interface arbitro_fifos_if #(parameter int DATA_W = 10);
  // Handshake: the FIFOs present show-ahead heads that are valid while
  // empty_FIFOE[i]=0, and they accept pushes while alm_full_FIFOS[d]=0.
  // A word moves only on a registered pop_FIFOE[g]/push_FIFOS[d] pair,
  // and data_out carries that word in the same cycle as the pair.
  logic [3:0]          empty_FIFOE;
  logic [3:0]          alm_full_FIFOS;
  logic [4*DATA_W-1:0] data_FIFOE;
  logic [3:0]          pop_FIFOE;
  logic [3:0]          push_FIFOS;
  logic [DATA_W-1:0]   data_out;

  modport master (
    input  empty_FIFOE, alm_full_FIFOS, data_FIFOE,
    output pop_FIFOE, push_FIFOS, data_out
  );

  modport slave (
    output empty_FIFOE, alm_full_FIFOS, data_FIFOE,
    input  pop_FIFOE, push_FIFOS, data_out
  );
endinterface

// File: rtl/arbitro_fifos.sv
// Scheduler that moves one word per cycle from the entry FIFOs to the exit FIFOs.
// Define ARB_PRIORIDAD_FIJA_EN to use fixed priority (lane 0 highest) instead of round-robin.
module arbitro_fifos #(
  parameter int         DATA_W     = 10,
  parameter logic [2:0] UMBRAL_RST = 3'd2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic [2:0]            umbral_in,
  arbitro_fifos_if.master       fifo,
  output logic [2:0]            umbral,
  output logic [3:0]            Estado,
  output logic                  idle,
  output logic [7:0]            xfer_count
);

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] head [4];
  logic [1:0]        dest [4];
  logic [3:0]        elig;
  logic [1:0]        start;
  logic [1:0]        idx;
  logic [1:0]        gnt_lane;
  logic              found;
  logic              grant_en;

  // The previous grant's pop/push registers mask the lane whose head has not
  // advanced yet and the destination whose almost-full flag still lags.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      head[i] = fifo.data_FIFOE[i*DATA_W +: DATA_W];
      dest[i] = head[i][DATA_W-1 -: 2];
      elig[i] = !fifo.empty_FIFOE[i] && !fifo.alm_full_FIFOS[dest[i]] &&
                !fifo.pop_FIFOE[i] && !fifo.push_FIFOS[dest[i]];
    end
  end

  always_comb begin
    found    = 1'b0;
    gnt_lane = 2'd0;
    idx      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && elig[idx]) begin
        found    = 1'b1;
        gnt_lane = idx;
      end
    end
  end

`ifdef ARB_PRIORIDAD_FIJA_EN
  assign start = 2'd0;
`else
  logic [1:0] ptr;

  assign start = ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 2'd0;
    end else if (grant_en) begin
      ptr <= gnt_lane + 2'd1;
    end
  end
`endif

  always_comb begin
    state_next = state;
    grant_en   = 1'b0;
    case (state)
      ST_RESET: state_next = ST_INIT;
      ST_INIT:  if (!init) state_next = ST_IDLE;
      ST_IDLE: begin
        if (init) begin
          state_next = ST_INIT;
        end else if (found) begin
          grant_en   = 1'b1;
          state_next = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (init) begin
          state_next = ST_INIT;
        end else if (found) begin
          grant_en = 1'b1;
        end else if (fifo.push_FIFOS == 4'd0) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_RESET;
      fifo.pop_FIFOE  <= 4'd0;
      fifo.push_FIFOS <= 4'd0;
      fifo.data_out   <= '0;
      umbral          <= UMBRAL_RST;
      xfer_count      <= 8'd0;
    end else begin
      state           <= state_next;
      fifo.pop_FIFOE  <= grant_en ? (4'b0001 << gnt_lane) : 4'd0;
      fifo.push_FIFOS <= grant_en ? (4'b0001 << dest[gnt_lane]) : 4'd0;
      if (grant_en) begin
        fifo.data_out <= head[gnt_lane];
        xfer_count    <= xfer_count + 8'd1;
      end
      if (state == ST_INIT && init) begin
        umbral <= umbral_in;
      end
    end
  end

  assign Estado = state;
  assign idle   = (state == ST_IDLE) && (&fifo.empty_FIFOE);

endmodule

// File: tb/tb_arbitro_fifos.sv
// Directed bench for arbitro_fifos: reset, configuration, single transfer,
// round-robin order, backpressure, init abort and asynchronous reset.
module tb_arbitro_fifos;
  localparam int DATA_W = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       init = 1'b0;
  logic [2:0] umbral_in = 3'd0;
  logic [2:0] umbral;
  logic [3:0] Estado;
  logic       idle;
  logic [7:0] xfer_count;
  int         checks = 0;
  int         errors = 0;

  arbitro_fifos_if #(.DATA_W(DATA_W)) bus ();

  arbitro_fifos #(.DATA_W(DATA_W), .UMBRAL_RST(3'd2)) dut (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .umbral_in  (umbral_in),
    .fifo       (bus.master),
    .umbral     (umbral),
    .Estado     (Estado),
    .idle       (idle),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset_config();
    rst = 1'b0;
    init = 1'b0;
    bus.empty_FIFOE = 4'hF;
    bus.alm_full_FIFOS = 4'h0;
    bus.data_FIFOE = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    init = 1'b1;
    umbral_in = 3'd5;
    tick();
    init = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    init = 1'b0;
    bus.empty_FIFOE = 4'hF;
    bus.alm_full_FIFOS = 4'h0;
    bus.data_FIFOE = '0;
    tick();
    tick();
    tick();
    checks++;
    if (bus.pop_FIFOE !== 4'd0 || bus.push_FIFOS !== 4'd0 || bus.data_out !== 10'd0) begin
      errors++;
      $display("FAIL reset_handshake pop=%b push=%b data=%h expected 0000 0000 000",
               bus.pop_FIFOE, bus.push_FIFOS, bus.data_out);
    end
    checks++;
    if (umbral !== 3'd2 || Estado !== 4'b0001 || idle !== 1'b0 || xfer_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_status umbral=%0d estado=%b idle=%b xfer=%0d expected 2 0001 0 0",
               umbral, Estado, idle, xfer_count);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (Estado !== 4'b0010) begin
      errors++;
      $display("FAIL reset_to_init estado=%b expected 0010", Estado);
    end
  endtask

  task automatic test_config();
    do_reset_config();
    checks++;
    if (umbral !== 3'd5 || Estado !== 4'b0100 || idle !== 1'b1) begin
      errors++;
      $display("FAIL config umbral=%0d estado=%b idle=%b expected 5 0100 1",
               umbral, Estado, idle);
    end
  endtask

  task automatic test_single_word();
    do_reset_config();
    bus.empty_FIFOE = 4'b1011;
    bus.data_FIFOE[20 +: 10] = 10'h2A5;
    tick();
    checks++;
    if (bus.pop_FIFOE !== 4'b0100 || bus.push_FIFOS !== 4'b0100 ||
        bus.data_out !== 10'h2A5 || xfer_count !== 8'd1 || Estado !== 4'b1000) begin
      errors++;
      $display("FAIL single_word pop=%b push=%b data=%h xfer=%0d estado=%b expected 0100 0100 2a5 1 1000",
               bus.pop_FIFOE, bus.push_FIFOS, bus.data_out, xfer_count, Estado);
    end
    bus.empty_FIFOE = 4'hF;
    tick();
    checks++;
    if (bus.pop_FIFOE !== 4'd0 || bus.push_FIFOS !== 4'd0 || Estado !== 4'b1000 || xfer_count !== 8'd1) begin
      errors++;
      $display("FAIL single_word_drain pop=%b push=%b estado=%b xfer=%0d expected 0000 0000 1000 1",
               bus.pop_FIFOE, bus.push_FIFOS, Estado, xfer_count);
    end
    tick();
    checks++;
    if (Estado !== 4'b0100 || idle !== 1'b1) begin
      errors++;
      $display("FAIL single_word_idle estado=%b idle=%b expected 0100 1", Estado, idle);
    end
  endtask

  task automatic test_fairness();
    logic [9:0] w [4];
    int         order [5];
    logic [3:0] exp_oh;
    w = '{10'h011, 10'h122, 10'h233, 10'h344};
    order = '{0, 1, 2, 3, 0};
    do_reset_config();
    for (int i = 0; i < 4; i++) bus.data_FIFOE[i*DATA_W +: DATA_W] = w[i];
    bus.empty_FIFOE = 4'h0;
    for (int n = 0; n < 5; n++) begin
      tick();
      exp_oh = 4'b0001 << order[n];
      checks++;
      if (bus.pop_FIFOE !== exp_oh || bus.push_FIFOS !== exp_oh || bus.data_out !== w[order[n]]) begin
        errors++;
        $display("FAIL fairness_%0d pop=%b push=%b data=%h expected %b %b %h",
                 n, bus.pop_FIFOE, bus.push_FIFOS, bus.data_out, exp_oh, exp_oh, w[order[n]]);
      end
    end
    checks++;
    if (xfer_count !== 8'd5) begin
      errors++;
      $display("FAIL fairness_count xfer=%0d expected 5", xfer_count);
    end
    init = 1'b1;
    tick();
    checks++;
    if (bus.pop_FIFOE !== 4'd0 || bus.push_FIFOS !== 4'd0 || Estado !== 4'b0010) begin
      errors++;
      $display("FAIL init_abort pop=%b push=%b estado=%b expected 0000 0000 0010",
               bus.pop_FIFOE, bus.push_FIFOS, Estado);
    end
    init = 1'b0;
    bus.empty_FIFOE = 4'hF;
  endtask

  task automatic test_backpressure();
    do_reset_config();
    bus.alm_full_FIFOS = 4'b0010;
    bus.data_FIFOE[0 +: 10] = 10'h1AA;
    bus.data_FIFOE[10 +: 10] = 10'h155;
    bus.empty_FIFOE = 4'b1100;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (bus.pop_FIFOE !== 4'd0 || bus.push_FIFOS !== 4'd0 || Estado !== 4'b0100) begin
        errors++;
        $display("FAIL backpressure_hold_%0d pop=%b push=%b estado=%b expected 0000 0000 0100",
                 n, bus.pop_FIFOE, bus.push_FIFOS, Estado);
      end
    end
    bus.alm_full_FIFOS = 4'b0000;
    tick();
    checks++;
    if (bus.pop_FIFOE !== 4'b0001 || bus.push_FIFOS !== 4'b0010 || bus.data_out !== 10'h1AA) begin
      errors++;
      $display("FAIL backpressure_lane0 pop=%b push=%b data=%h expected 0001 0010 1aa",
               bus.pop_FIFOE, bus.push_FIFOS, bus.data_out);
    end
    tick();
    checks++;
    if (bus.pop_FIFOE !== 4'd0 || bus.push_FIFOS !== 4'd0) begin
      errors++;
      $display("FAIL backpressure_gap pop=%b push=%b expected 0000 0000",
               bus.pop_FIFOE, bus.push_FIFOS);
    end
    tick();
    checks++;
    if (bus.pop_FIFOE !== 4'b0010 || bus.push_FIFOS !== 4'b0010 || bus.data_out !== 10'h155) begin
      errors++;
      $display("FAIL backpressure_lane1 pop=%b push=%b data=%h expected 0010 0010 155",
               bus.pop_FIFOE, bus.push_FIFOS, bus.data_out);
    end
    bus.empty_FIFOE = 4'hF;
  endtask

  task automatic test_async_reset();
    do_reset_config();
    bus.data_FIFOE[30 +: 10] = 10'h0C3;
    bus.empty_FIFOE = 4'b0111;
    tick();
    checks++;
    if (bus.pop_FIFOE !== 4'b1000 || bus.push_FIFOS !== 4'b0001 || bus.data_out !== 10'h0C3) begin
      errors++;
      $display("FAIL async_pre pop=%b push=%b data=%h expected 1000 0001 0c3",
               bus.pop_FIFOE, bus.push_FIFOS, bus.data_out);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.pop_FIFOE !== 4'd0 || bus.push_FIFOS !== 4'd0 || bus.data_out !== 10'd0 ||
        Estado !== 4'b0001 || xfer_count !== 8'd0 || umbral !== 3'd2) begin
      errors++;
      $display("FAIL async_reset pop=%b push=%b data=%h estado=%b xfer=%0d umbral=%0d expected 0000 0000 000 0001 0 2",
               bus.pop_FIFOE, bus.push_FIFOS, bus.data_out, Estado, xfer_count, umbral);
    end
    tick();
    rst = 1'b1;
  endtask

  initial begin
    bus.empty_FIFOE = 4'hF;
    bus.alm_full_FIFOS = 4'h0;
    bus.data_FIFOE = '0;
    test_reset();
    test_config();
    test_single_word();
    test_fairness();
    test_backpressure();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
